// File: rtl/pcu_pkg.sv
// Shared definitions for the program counter unit: state encoding,
// default reset/trap addresses and the datapath width.
package pcu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SHADOW = 2'd1,
    HALTED = 2'd2
  } pcu_state_e;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC    = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR = 32'h0000_0100;

endpackage

// File: rtl/program_counter_unit_next_pc_select.sv
// next_pc_select: combinational next-fetch-address logic. Picks the
// branch/JAL or JALR target, clears the JALR low bit, detects misaligned
// targets and forms PC+4.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned target -> trap vector).
module next_pc_select
  import pcu_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  input  logic            jump,
  input  logic            is_jalr,
  output logic [XLEN-1:0] pc_plus_4,
  output logic [XLEN-1:0] redirect_target,
  output logic            misaligned
);

  logic            use_jalr;
  logic [XLEN-1:0] sel_target;
  logic [XLEN-1:0] aligned_target;

  // Target mux, JALR bit-0 clear, alignment and misalignment detection
  always_comb begin
    use_jalr       = jump & is_jalr;
    sel_target     = use_jalr ? jump_target : branch_target;
    sel_target     = sel_target & ~{{(XLEN-1){1'b0}}, use_jalr};
    aligned_target = sel_target & ~{{(XLEN-2){1'b0}}, 2'b11};
`ifdef MISALIGN_TRAP_EN
    misaligned     = sel_target[1];
`else
    misaligned     = 1'b0;
`endif
    redirect_target = misaligned ? TRAP_VECTOR : aligned_target;
    pc_plus_4       = pc + 32'd4;
  end

endmodule

// File: rtl/program_counter_unit.sv
// program_counter_unit: fetch-side PC sequencer. Owns the PC register,
// sequences RUN/SHADOW/HALTED, raises Flush on redirects and counts them.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned redirect traps).
module program_counter_unit
  import pcu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Branch_And,
  input  logic            Jump,
  input  logic [XLEN-1:0] Branch_Target,
  input  logic [XLEN-1:0] Jump_Target,
  input  logic            Is_Jalr,
  input  logic            Stall,
  input  logic            Halt,
  input  logic            Resume,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_Plus_4,
  output logic            Flush,
  output logic            Halted,
  output logic            Trap,
  output logic [XLEN-1:0] Redirect_Count
);

  pcu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cnt_q, cnt_d;

  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] pc_plus_4;
  logic            misaligned;

  next_pc_select #(
    .TRAP_VECTOR(TRAP_VECTOR)
  ) u_next_pc_select (
    .pc              (PC),
    .branch_target   (Branch_Target),
    .jump_target     (Jump_Target),
    .jump            (Jump),
    .is_jalr         (Is_Jalr),
    .pc_plus_4       (pc_plus_4),
    .redirect_target (redirect_target),
    .misaligned      (misaligned)
  );

  // Redirect inputs only matter while running; SHADOW and HALTED ignore them
  always_comb begin
    redirect = (state_q == RUN) & (Branch_And | Jump);
  end

  // State, PC and redirect counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: redirect beats Stall, Stall beats Halt
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (redirect)   state_d = SHADOW;
        else if (Stall) state_d = RUN;
        else if (Halt)  state_d = HALTED;
      end
      SHADOW:  state_d = RUN;
      HALTED:  if (Resume) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Next PC and counter, following the same priority as the state logic
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          pc_d  = redirect_target;
          cnt_d = cnt_q + 32'd1;
        end else if (!Stall && !Halt) begin
          pc_d  = pc_plus_4;
        end
      end
      SHADOW:  pc_d = pc_plus_4;
      HALTED:  if (Resume) pc_d = pc_plus_4;
      default: pc_d = pc_q;
    endcase
  end

  // Outputs; reset forces the documented quiet values even before the edge
  always_comb begin
    PC             = rst ? RESET_PC : pc_q;
    PC_Plus_4      = pc_plus_4;
    Flush          = ~rst & redirect;
    Trap           = ~rst & redirect & misaligned;
    Halted         = ~rst & (state_q == HALTED);
    Redirect_Count = cnt_q;
  end

endmodule

// File: doc/program_counter_unit.md
# program_counter_unit

Fetch-side PC sequencer. Consumes the taken-branch decision from the branch control unit and the jump/target signals from EX. It owns the PC register, selects the next fetch address, and generates the pipeline flush on redirects. It also handles halt/resume, counts redirects, and optionally traps on misaligned targets.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100: redirect address on a misaligned target (used only with the macro).
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Branch_And  in  1  taken-branch decision for the instruction in EX.
- Jump  in  1  JAL/JALR in EX.
- Branch_Target  in  32  PC_EX + imm (branch/JAL target).
- Jump_Target  in  32  ALU result for JALR; bit 0 is cleared inside this block.
- Is_Jalr  in  1  selects Jump_Target over Branch_Target when Jump=1.
- Stall  in  1  hazard-unit freeze of the fetch stage.
- Halt  in  1  ECALL/EBREAK decoded in ID.
- Resume  in  1  external restart from HALTED.
- PC  out  32  current fetch address.
- PC_Plus_4  out  32  PC + 4, combinational.
- Flush  out  1  squash IF/ID and ID/EX.
- Halted  out  1  high in HALTED.
- Trap  out  1  misaligned-target trap pulse; tied 0 without the macro.
- Redirect_Count  out  32  number of accepted redirects.

## Operation
- **States:** RUN, SHADOW, HALTED. The state is encoded in 2 bits.
- **Redirect** means (Branch_And | Jump) while in RUN.
- **Target selection:** Jump & Is_Jalr gives {Jump_Target[31:1],1'b0}; otherwise Branch_Target.
- **RUN priority:** rst > redirect > Stall > Halt > advance.
  - Redirect: PC <= target, Flush=1, go to SHADOW, Redirect_Count++.
  - Stall (no redirect): PC holds, Flush=0.
  - Halt (no redirect, no Stall): PC holds, go to HALTED. The instruction in ID does not advance.
  - Otherwise: PC <= PC+4.
- **SHADOW** lasts one cycle. EX holds a flushed bubble, so Branch_And, Jump, Stall and Halt are all ignored. PC <= PC+4, Flush=0, then return to RUN.
- **HALTED:** PC holds, Halted=1, Flush=0, and all redirect inputs are ignored. Resume=1 sets PC <= PC+4 and returns to RUN.
- **Reset:** rst=1 at any edge, in any state, sets PC=RESET_PC, state=RUN, Redirect_Count=0.
- **Output values during reset and the first cycle after it:** PC=RESET_PC, Flush=0, Halted=0, Trap=0.
- **Arithmetic:** all PC math is 32-bit and wraps modulo 2^32, so PC=32'hFFFF_FFFC advances to 0. Redirect_Count wraps from 32'hFFFF_FFFF to 0.
- **Simultaneous events:** redirect together with Halt or Stall means redirect wins and Halt is discarded, because the halting instruction is younger and squashed.

## Timing
- PC, state and Redirect_Count are registered and update on the rising edge.
- Flush and Trap are combinational and valid in the same cycle as the redirect inputs. The IF/ID and ID/EX registers act on Flush at that same edge.
- Redirect-to-fetch latency is 1 cycle: the target appears on PC in the cycle after Branch_And/Jump. Taken-branch penalty is 2 squashed instructions.
- Halt to Halted=1 is 1 cycle. Resume to PC advancing is 1 cycle.

## Configuration
- Macro: MISALIGN_TRAP_EN.
- **Defined:** a redirect whose selected target has target[1]=1 is a misaligned redirect.
  - PC <= TRAP_VECTOR, Trap=1 for that cycle, Flush=1.
  - The block goes to SHADOW and Redirect_Count increments.
- **Undefined:**
  - Target bits [1:0] are forced to 00 and no trap is taken.
  - Trap is tied to 0.
  - TRAP_VECTOR is unused.

## Structure
- **Shared package pcu_pkg:** state encodings (RUN=2'd0, SHADOW=2'd1, HALTED=2'd2), default RESET_PC and TRAP_VECTOR, and the 32-bit XLEN constant.
- **Sub-module next_pc_select (combinational):** target mux, JALR bit-0 clear, the misalignment check and PC+4. The top level holds the FSM, the PC register and the counter.

## Test plan
- **Reset:** rst=1 for 2 cycles with RESET_PC=32'h0 -> PC=0, Flush=0, Halted=0, Redirect_Count=0. Then 3 free cycles -> PC=4, 8, 12.
- **Taken branch:** PC=0x10, Branch_And=1, Branch_Target=0x40 -> Flush=1 that cycle, next PC=0x40. Branch_And=1 during SHADOW is ignored, so PC=0x44 on the following cycle and Redirect_Count=1.
- **JALR:** Jump=1, Is_Jalr=1, Jump_Target=0x81 -> PC=0x80, Flush=1. With MISALIGN_TRAP_EN and Jump_Target=0x82 -> PC=0x100, Trap=1.
- **Stall, then redirect over stall:**
  - Stall=1 for 3 cycles at PC=0x20 -> PC holds at 0x20.
  - Stall=1 with Branch_And=1, target 0x200 -> PC=0x200.
- **Halt/Resume:**
  - Halt=1 at PC=0x30 -> Halted=1, PC holds at 0x30 for 5 cycles even with Branch_And=1.
  - Resume=1 -> PC=0x34, Halted=0.
  - Halt and Branch_And in the same cycle -> redirect taken, Halted stays 0.
- **Wrap and reset mid-operation:**
  - PC=32'hFFFF_FFFC advances -> PC=0.
  - rst asserted in SHADOW or HALTED -> PC=RESET_PC, state RUN the next cycle.
